// File: rtl/fpu_divsqrt_sched_pkg.sv
// Shared definitions for the divide/sqrt scheduler: op encodings, FSM states, default latencies.
// The early-out build (FPU_DIVSQRT_EARLYOUT_EN) uses the same package unchanged.
package fpu_divsqrt_sched_pkg;

    localparam logic [1:0] FDS_DIVS  = 2'b00;
    localparam logic [1:0] FDS_DIVD  = 2'b01;
    localparam logic [1:0] FDS_SQRTS = 2'b10;
    localparam logic [1:0] FDS_SQRTD = 2'b11;

    localparam int FDS_LAT_S_DEF = 8;
    localparam int FDS_LAT_D_DEF = 14;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        WB   = 2'd2
    } fds_state_t;

    function automatic logic fds_is_double(input logic [1:0] op);
        logic dbl;
        case (op)
            FDS_DIVD, FDS_SQRTD: dbl = 1'b1;
            FDS_DIVS, FDS_SQRTS: dbl = 1'b0;
            default:             dbl = 1'b0;
        endcase
        return dbl;
    endfunction

endpackage

// File: rtl/fpu_divsqrt_sched_rr_arb.sv
// Combinational round-robin arbiter: first requester at or after ptr, wrapping.
// Returns a one-hot grant plus its encoded index; the pointer register lives in the caller.
module fpu_rr_arb #(
    parameter int NREQ  = 3,
    parameter int IDX_W = 2
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic [NREQ-1:0]  gnt,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    logic [IDX_W-1:0] cand [NREQ];

    // cand[k] is the port examined at priority position k.
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_cand
        assign cand[gi] = IDX_W'((int'(ptr) + gi) % NREQ);
    end

    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        // Walk from lowest priority to highest so the highest-priority hit is the last written.
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[cand[i]]) begin
                idx = cand[i];
                any = 1'b1;
            end
        end
        if (any) begin
            gnt[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/fpu_divsqrt_sched.sv
// Scheduler for one shared iterative FP divide/sqrt unit: round-robin grant, latency count, writeback hold.
// Optional FPU_DIVSQRT_EARLYOUT_EN adds req_special/dv_special and a 1-cycle path for special operands.
module fpu_divsqrt_sched
    import fpu_divsqrt_sched_pkg::*;
#(
    parameter int NREQ  = 3,
    parameter int TAG_W = 9,
    parameter int LAT_S = FDS_LAT_S_DEF,
    parameter int LAT_D = FDS_LAT_D_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_vld,
    input  logic [2*NREQ-1:0]     req_op,
    input  logic [TAG_W*NREQ-1:0] req_tag,
    output logic [NREQ-1:0]       req_ready,
`ifdef FPU_DIVSQRT_EARLYOUT_EN
    input  logic [NREQ-1:0]       req_special,
    output logic                  dv_special,
`endif
    input  logic                  flush,
    output logic                  dv_start,
    output logic [1:0]            dv_op,
    output logic [1:0]            dv_sel,
    output logic                  wb_vld,
    output logic [TAG_W-1:0]      wb_tag,
    input  logic                  wb_ack,
    output logic                  busy
);

    localparam int IDX_W   = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int LAT_MAX = (LAT_S > LAT_D) ? LAT_S : LAT_D;
    localparam int CNT_W   = (LAT_MAX > 1) ? $clog2(LAT_MAX) : 1;

    logic [1:0]       op_arr  [NREQ];
    logic [TAG_W-1:0] tag_arr [NREQ];

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
        assign op_arr[gi]  = req_op[2*gi +: 2];
        assign tag_arr[gi] = req_tag[TAG_W*gi +: TAG_W];
    end

    fds_state_t       state_q, state_d;
    logic [IDX_W-1:0] rr_q, rr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       op_q, op_d;
    logic [1:0]       sel_q, sel_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic             start_q, start_d;
    logic             wb_vld_q, wb_vld_d;
    logic             busy_q, busy_d;
    logic             special_q, special_d;

    logic [NREQ-1:0]  arb_gnt;
    logic [IDX_W-1:0] arb_idx;
    logic             arb_any;
    logic             accept;
    logic             cur_special;
    logic [CNT_W-1:0] lat_m1;

    fpu_rr_arb #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .req (req_vld),
        .ptr (rr_q),
        .gnt (arb_gnt),
        .idx (arb_idx),
        .any (arb_any)
    );

    // A flush in the accept cycle kills the grant outright, so the pointer never moves.
    assign accept    = (state_q == IDLE) && arb_any && !flush && !rst;
    assign req_ready = accept ? arb_gnt : '0;

`ifdef FPU_DIVSQRT_EARLYOUT_EN
    assign cur_special = req_special[arb_idx];
    assign dv_special  = special_q;
`else
    assign cur_special = 1'b0;
`endif

    always_comb begin
        lat_m1 = fds_is_double(op_arr[arb_idx]) ? CNT_W'(LAT_D - 1) : CNT_W'(LAT_S - 1);
        if (cur_special) begin
            lat_m1 = '0;
        end
    end

    always_comb begin
        state_d   = state_q;
        rr_d      = rr_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        sel_d     = sel_q;
        tag_d     = tag_q;
        special_d = special_q;
        wb_vld_d  = wb_vld_q;
        start_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    op_d      = op_arr[arb_idx];
                    sel_d     = 2'(arb_idx);
                    tag_d     = tag_arr[arb_idx];
                    special_d = cur_special;
                    rr_d      = (arb_idx == IDX_W'(NREQ - 1)) ? '0 : arb_idx + 1'b1;
                    cnt_d     = lat_m1;
                    start_d   = 1'b1;
                    state_d   = RUN;
                end
            end
            RUN: begin
                if (cnt_q == '0) begin
                    state_d  = WB;
                    wb_vld_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            WB: begin
                if (wb_ack && wb_vld_q) begin
                    state_d  = IDLE;
                    wb_vld_d = 1'b0;
                end
            end
            default: begin
                state_d  = IDLE;
                wb_vld_d = 1'b0;
            end
        endcase

        // Flush beats everything, including a same-cycle writeback ack.
        if (flush) begin
            state_d  = IDLE;
            wb_vld_d = 1'b0;
            start_d  = 1'b0;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            rr_q      <= '0;
            cnt_q     <= '0;
            op_q      <= '0;
            sel_q     <= '0;
            tag_q     <= '0;
            special_q <= 1'b0;
            start_q   <= 1'b0;
            wb_vld_q  <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_q      <= rr_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            sel_q     <= sel_d;
            tag_q     <= tag_d;
            special_q <= special_d;
            start_q   <= start_d;
            wb_vld_q  <= wb_vld_d;
            busy_q    <= busy_d;
        end
    end

    assign dv_start = start_q;
    assign dv_op    = op_q;
    assign dv_sel   = sel_q;
    assign wb_vld   = wb_vld_q;
    assign wb_tag   = tag_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_fpu_divsqrt_sched.sv
// Directed bench for fpu_divsqrt_sched: timestamp-based transaction model checked every cycle,
// plus literal expectations per scenario. Define FPU_DIVSQRT_EARLYOUT_EN to exercise the early-out path.
`timescale 1ns/1ps
module tb_fpu_divsqrt_sched;

    localparam int NREQ  = 3;
    localparam int TAG_W = 9;
    localparam int LAT_S = 8;
    localparam int LAT_D = 14;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [NREQ-1:0]       req_vld = '0;
    logic [2*NREQ-1:0]     req_op = '0;
    logic [TAG_W*NREQ-1:0] req_tag = '0;
    logic                  flush = 1'b0;
    logic                  wb_ack = 1'b0;
    logic [NREQ-1:0]       req_ready;
    logic                  dv_start;
    logic [1:0]            dv_op;
    logic [1:0]            dv_sel;
    logic                  wb_vld;
    logic [TAG_W-1:0]      wb_tag;
    logic                  busy;
`ifdef FPU_DIVSQRT_EARLYOUT_EN
    logic [NREQ-1:0]       req_special = '0;
    logic                  dv_special;
`endif

    fpu_divsqrt_sched #(
        .NREQ  (NREQ),
        .TAG_W (TAG_W),
        .LAT_S (LAT_S),
        .LAT_D (LAT_D)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_vld     (req_vld),
        .req_op      (req_op),
        .req_tag     (req_tag),
        .req_ready   (req_ready),
`ifdef FPU_DIVSQRT_EARLYOUT_EN
        .req_special (req_special),
        .dv_special  (dv_special),
`endif
        .flush       (flush),
        .dv_start    (dv_start),
        .dv_op       (dv_op),
        .dv_sel      (dv_sel),
        .wb_vld      (wb_vld),
        .wb_tag      (wb_tag),
        .wb_ack      (wb_ack),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;
    int glog_port[$];
    int glog_cyc[$];

    // Transaction model: one op in flight, described by its accept cycle and latency.
    bit               m_active = 1'b0;
    int               m_t0 = 0;
    int               m_lat = 0;
    int               m_rr = 0;
    logic [1:0]       m_op = '0;
    logic [1:0]       m_sel = '0;
    logic [TAG_W-1:0] m_tag = '0;
    logic             m_spec = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [NREQ-1:0] exp_ready;
        logic            exp_start;
        logic            exp_wbv;
        logic            sp;
        int              p;
        if (chk_en) begin
            exp_ready = '0;
            p = -1;
            if (!m_active && !flush && !rst) begin
                for (int k = 0; k < NREQ; k++) begin
                    if (p < 0 && req_vld[(m_rr + k) % NREQ]) p = (m_rr + k) % NREQ;
                end
            end
            if (p >= 0) exp_ready[p] = 1'b1;
            exp_start = m_active && (cyc == m_t0 + 1);
            exp_wbv   = m_active && (cyc >= m_t0 + 1 + m_lat);

            check("req_ready", 32'(req_ready), 32'(exp_ready));
            check("dv_start", 32'(dv_start), 32'(exp_start));
            check("wb_vld", 32'(wb_vld), 32'(exp_wbv));
            check("busy", 32'(busy), 32'(m_active));
            check("dv_op", 32'(dv_op), 32'(m_op));
            check("dv_sel", 32'(dv_sel), 32'(m_sel));
            check("wb_tag", 32'(wb_tag), 32'(m_tag));
`ifdef FPU_DIVSQRT_EARLYOUT_EN
            check("dv_special", 32'(dv_special), 32'(m_spec));
            sp = req_special[(p >= 0) ? p : 0];
`else
            sp = 1'b0;
`endif
            if (rst) begin
                m_active = 1'b0; m_rr = 0; m_op = '0; m_sel = '0; m_tag = '0; m_spec = 1'b0;
            end else if (flush) begin
                m_active = 1'b0;
            end else if (p >= 0) begin
                m_active = 1'b1;
                m_t0     = cyc;
                m_op     = req_op[2*p +: 2];
                m_sel    = 2'(p);
                m_tag    = req_tag[TAG_W*p +: TAG_W];
                m_spec   = sp;
                m_lat    = sp ? 1 : (m_op[0] ? LAT_D : LAT_S);
                m_rr     = (p + 1) % NREQ;
                glog_port.push_back(p);
                glog_cyc.push_back(cyc);
            end else if (exp_wbv && wb_ack) begin
                m_active = 1'b0;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_wb(input int budget, output int wcyc);
        int n = 0;
        while (wb_vld !== 1'b1 && n < budget) begin
            tick(1);
            n++;
        end
        if (wb_vld !== 1'b1) check("wb_timeout", 32'(wb_vld), 32'd1);
        wcyc = cyc;
    endtask

    task automatic ack_once();
        wb_ack = 1'b1;
        tick(1);
        wb_ack = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int a, w, n, n0, flushed_wb;
        int exp_ord [4] = '{0, 1, 2, 0};

        tick(1);
        chk_en = 1'b1;
        tick(1);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_wb_tag", 32'(wb_tag), 32'd0);
        rst = 1'b0;
        tick(1);

        // 1: single divD request on port 1
        req_op[3:2] = 2'b01;
        req_tag[TAG_W*1 +: TAG_W] = 9'h05;
        req_vld = 3'b010;
        a = cyc;
        #1;
        check("t1_ready", 32'(req_ready), 32'h2);
        tick(1);
        req_vld = '0;
        check("t1_start", 32'(dv_start), 32'd1);
        check("t1_sel", 32'(dv_sel), 32'd1);
        wait_wb(40, w);
        check("t1_latency", 32'(w - a), 32'd15);
        check("t1_tag", 32'(wb_tag), 32'h05);
        ack_once();
        check("t1_idle", 32'(busy), 32'd0);

        // 2: all ports request sqrtS with acks always high
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        req_op  = 6'b10_10_10;
        req_tag = {9'h12, 9'h11, 9'h10};
        wb_ack  = 1'b1;
        n0 = glog_port.size();
        req_vld = 3'b111;
        n = 0;
        while (glog_port.size() < n0 + 4 && n < 80) begin
            tick(1);
            n++;
        end
        req_vld = '0;
        n = 0;
        while (busy === 1'b1 && n < 30) begin
            tick(1);
            n++;
        end
        check("t2_drain", 32'(busy), 32'd0);
        wb_ack = 1'b0;
        if (glog_port.size() < n0 + 4) begin
            check("t2_grants", 32'(glog_port.size() - n0), 32'd4);
        end else begin
            for (int i = 0; i < 4; i++) check("t2_order", 32'(glog_port[n0 + i]), 32'(exp_ord[i]));
            for (int i = 0; i < 3; i++)
                check("t2_spacing", 32'(glog_cyc[n0 + i + 1] - glog_cyc[n0 + i]), 32'd10);
        end

        // 3: writeback held for 20 cycles
        req_op[1:0] = 2'b00;
        req_tag[8:0] = 9'h1A3;
        req_vld = 3'b001;
        tick(1);
        req_vld = '0;
        wait_wb(20, w);
        req_vld = 3'b110;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            check("t3_hold_vld", 32'(wb_vld), 32'd1);
            check("t3_hold_tag", 32'(wb_tag), 32'h1A3);
            check("t3_hold_ready", 32'(req_ready), 32'd0);
        end
        req_vld = '0;
        ack_once();
        check("t3_idle", 32'(busy), 32'd0);

        // 4: flush in RUN cycle 5 of a divD, then a fresh divD
        req_op[5:4] = 2'b01;
        req_tag[TAG_W*2 +: TAG_W] = 9'h77;
        req_vld = 3'b100;
        tick(1);
        req_vld = '0;
        tick(4);
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
        check("t4_flush_idle", 32'(busy), 32'd0);
        flushed_wb = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (wb_vld === 1'b1) flushed_wb++;
        end
        check("t4_no_wb", 32'(flushed_wb), 32'd0);
        req_op[1:0] = 2'b01;
        req_tag[8:0] = 9'h0C4;
        req_vld = 3'b001;
        a = cyc;
        tick(1);
        req_vld = '0;
        wait_wb(40, w);
        check("t4_fresh_latency", 32'(w - a), 32'd15);
        ack_once();

        // 5: flush coincident with a port2 accept (pointer now at 1)
        req_op[5:4] = 2'b00;
        req_tag[TAG_W*2 +: TAG_W] = 9'h0EE;
        req_vld = 3'b101;
        flush = 1'b1;
        #1;
        check("t5_ready_killed", 32'(req_ready), 32'd0);
        tick(1);
        flush = 1'b0;
        #1;
        check("t5_no_start", 32'(dv_start), 32'd0);
        check("t5_port2_next", 32'(req_ready), 32'h4);
        tick(1);
        req_vld = '0;
        check("t5_start", 32'(dv_start), 32'd1);
        check("t5_sel", 32'(dv_sel), 32'd2);
        wait_wb(20, w);
        check("t5_tag", 32'(wb_tag), 32'h0EE);
        ack_once();

        // 6: reset in the middle of an op
        req_op[1:0] = 2'b11;
        req_tag[8:0] = 9'h101;
        req_vld = 3'b001;
        tick(1);
        req_vld = '0;
        tick(3);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_tag", 32'(wb_tag), 32'd0);
        tick(3);

`ifdef FPU_DIVSQRT_EARLYOUT_EN
        // 7: special operand takes the one-cycle path
        req_op[3:2] = 2'b01;
        req_tag[TAG_W*1 +: TAG_W] = 9'h033;
        req_special = 3'b010;
        req_vld = 3'b010;
        tick(1);
        req_vld = '0;
        req_special = '0;
        check("t7_special", 32'(dv_special), 32'd1);
        tick(1);
        check("t7_wb_at_2", 32'(wb_vld), 32'd1);
        ack_once();
`endif

        tick(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
